lfsr_bmc_transmitter: RTL

//   Lighthouse-side counterpart of the LFSR decode/polynomial-identification path.

---
 rtl/lfsr_bmc_transmitter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lfsr_bmc_transmitter.sv
// lfsr_bmc_transmitter
//   Generates the 17-bit LFSR bit sequence for a given polynomial and seed and
//   drives it Biphase-Mark-Coded on data_out, one bit every BIT_CLKS clocks.
//   A free-running timestamp counter is captured in the first bit cycle of
//   each frame so loopback benches get known (polynomial, iteration, time) data.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | line quiet, ready=1, waiting for start
//   SEND    | frame on the line, envelope=1
//   END     | one cycle after the last bit, done pulse, ready=1
//
// Ports
//   clk_96MHz    in   system clock
//   reset        in   synchronous active-high reset
//   start        in   frame request, taken when ready=1
//   abort        in   stop the frame in progress, no done pulse
//   polynomial   in   LFSR taps, sampled on accept
//   start_data   in   LFSR seed, sampled on accept
//   length       in   number of bits to send, sampled on accept
//   ready        out  start will be accepted
//   envelope     out  high while a frame is on the line
//   data_out     out  BMC line
//   lfsr_state   out  LFSR state generating the current bit
//   iteration    out  index of the current bit
//   ts_first_bit out  timestamp in the first bit cycle of the last frame
//   done         out  1-cycle pulse, frame completed (or zero-length frame)
//   error        out  1-cycle pulse, start rejected (zero seed or polynomial)
module lfsr_bmc_transmitter #(
    parameter int BIT_CLKS = 16,
    parameter int TS_WIDTH = 24
) (
    input  logic                clk_96MHz,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [16:0]         polynomial,
    input  logic [16:0]         start_data,
    input  logic [16:0]         length,
    output logic                ready,
    output logic                envelope,
    output logic                data_out,
    output logic [16:0]         lfsr_state,
    output logic [16:0]         iteration,
    output logic [TS_WIDTH-1:0] ts_first_bit,
    output logic                done,
    output logic                error
);

    localparam int CW = $clog2(BIT_CLKS);
    localparam logic [CW-1:0] CLK_LAST = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CLK_HALF = CW'(BIT_CLKS / 2);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_END} state_t;

    state_t              state, state_next;
    logic [16:0]         poly_q;
    logic [16:0]         bits_left;
    logic [CW-1:0]       clk_cnt;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [16:0]         lfsr_next;

    logic accept, reject, empty, bit_end, frame_end, half_toggle, do_abort;

    assign lfsr_next = {1'b0, lfsr_state[16:1]} ^ (lfsr_state[0] ? poly_q : 17'h0);

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        reject      = 1'b0;
        empty       = 1'b0;
        bit_end     = 1'b0;
        frame_end   = 1'b0;
        half_toggle = 1'b0;
        do_abort    = 1'b0;
        case (state)
            ST_IDLE, ST_END: begin
                state_next = ST_IDLE;
                if (start) begin
                    if (polynomial == 17'h0 || start_data == 17'h0) begin
                        reject = 1'b1;
                    end else if (length == 17'h0) begin
                        empty = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                if (abort) begin
                    do_abort   = 1'b1;
                    state_next = ST_IDLE;
                end else if (clk_cnt == '0) begin
                    // bits_left counts the bits still to go after the current one
                    if (bits_left == 17'h0) begin
                        frame_end  = 1'b1;
                        state_next = ST_END;
                    end else begin
                        bit_end = 1'b1;
                    end
                end else begin
                    // mid-bit transition encodes a one
                    half_toggle = (clk_cnt == CLK_HALF) && lfsr_state[0];
                end
            end
            default: state_next = ST_IDLE;
        endcase
        ready    = (state != ST_SEND);
        envelope = (state == ST_SEND);
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            state        <= ST_IDLE;
            poly_q       <= 17'h0;
            bits_left    <= 17'h0;
            clk_cnt      <= '0;
            ts_cnt       <= '0;
            ts_first_bit <= '0;
            lfsr_state   <= 17'h0;
            iteration    <= 17'h0;
            data_out     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            state  <= state_next;
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
            done   <= empty | frame_end;
            error  <= reject;
            if (accept) begin
                poly_q       <= polynomial;
                lfsr_state   <= start_data;
                iteration    <= 17'h0;
                bits_left    <= length - 17'd1;
                clk_cnt      <= CLK_LAST;
                data_out     <= 1'b1;
                // value the counter will hold in the first bit cycle
                ts_first_bit <= ts_cnt + TS_WIDTH'(1);
            end
            if (do_abort || frame_end) begin
                data_out <= 1'b0;
            end
            if (bit_end) begin
                lfsr_state <= lfsr_next;
                iteration  <= iteration + 17'd1;
                bits_left  <= bits_left - 17'd1;
                clk_cnt    <= CLK_LAST;
                data_out   <= ~data_out;
            end
            if (state == ST_SEND && !abort && clk_cnt != '0) begin
                clk_cnt <= clk_cnt - CW'(1);
            end
            if (half_toggle) begin
                data_out <= ~data_out;
            end
        end
    end

endmodule
